// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the instruction memory loader
// Contents:
//   loader_state_t : loader FSM states
//   HDR_BYTES      : bytes in the frame header (16-bit word count)
//   BYTES_PER_WORD : bytes assembled into one instruction word
package mips_pkg;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_HI,
        ST_HDR_LO,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-serial instruction memory loader with checksum and core reset release
// Ports:
//   f_clk, rst           : clock, synchronous active-low reset
//   start                : begin a load (honoured in IDLE, DONE, ERR)
//   in_valid/in_data     : framed byte stream from the host
//   in_ready             : byte accepted this cycle when in_valid is also high
//   mem_we/addr/wdata    : instruction memory write port (one-cycle strobe)
//   cpu_rst              : core reset, active-low, released only after a good load
//   done/err             : load result flags
//   words_loaded         : words written in the current or last load
module imem_loader
    import mips_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          f_clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          cpu_rst,
    output logic          done,
    output logic          err,
    output logic [AW:0]   words_loaded
);

    localparam logic [15:0] DEPTH_W  = 16'(DEPTH);
    localparam logic [1:0]  LAST_IDX = 2'(BYTES_PER_WORD - 1);

    loader_state_t state_q, state_d;

    logic [7:0]    xor_q, xor_d;
    logic [1:0]    idx_q, idx_d;
    logic [23:0]   asm_q, asm_d;
    logic [15:0]   count_q, count_d;
    logic [AW:0]   words_d;
    logic [AW:0]   words_inc;
    logic [AW-1:0] addr_d;
    logic [31:0]   wdata_d;
    logic          we_d;
    logic [15:0]   hdr_count;
    logic          accept;

    assign accept    = in_valid && in_ready;
    assign words_inc = words_loaded + (AW+1)'(1);
    assign hdr_count = {count_q[15:8], in_data};

    always_comb begin
        state_d = state_q;
        xor_d   = xor_q;
        idx_d   = idx_q;
        asm_d   = asm_q;
        count_d = count_q;
        words_d = words_loaded;
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
        we_d    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_HDR_HI;
                    xor_d   = 8'h00;
                    idx_d   = 2'd0;
                    words_d = '0;
                end
            end
            ST_HDR_HI: begin
                if (accept) begin
                    count_d[15:8] = in_data;
                    xor_d         = xor_q ^ in_data;
                    state_d       = ST_HDR_LO;
                end
            end
            ST_HDR_LO: begin
                if (accept) begin
                    count_d[7:0] = in_data;
                    xor_d        = xor_q ^ in_data;
                    if (hdr_count > DEPTH_W)
                        state_d = ST_ERR;
                    else if (hdr_count == 16'd0)
                        state_d = ST_CSUM;
                    else
                        state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    xor_d = xor_q ^ in_data;
                    if (idx_q == LAST_IDX) begin
                        // Word complete: the earlier three bytes sit in asm_q, MSB first.
                        we_d    = 1'b1;
                        addr_d  = words_loaded[AW-1:0];
                        wdata_d = {asm_q, in_data};
                        words_d = words_inc;
                        idx_d   = 2'd0;
                        if (16'(words_inc) == count_q)
                            state_d = ST_CSUM;
                    end else begin
                        asm_d = {asm_q[15:0], in_data};
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            ST_CSUM: begin
                if (accept)
                    state_d = (in_data == xor_q) ? ST_DONE : ST_ERR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Flag outputs are registered from the next state so they line up with it.
    always_ff @(posedge f_clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            xor_q        <= 8'h00;
            idx_q        <= 2'd0;
            asm_q        <= 24'h0;
            count_q      <= 16'h0;
            words_loaded <= '0;
            mem_addr     <= '0;
            mem_wdata    <= 32'h0;
            mem_we       <= 1'b0;
            in_ready     <= 1'b0;
            cpu_rst      <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            state_q      <= state_d;
            xor_q        <= xor_d;
            idx_q        <= idx_d;
            asm_q        <= asm_d;
            count_q      <= count_d;
            words_loaded <= words_d;
            mem_addr     <= addr_d;
            mem_wdata    <= wdata_d;
            mem_we       <= we_d;
            in_ready     <= state_d inside {ST_HDR_HI, ST_HDR_LO, ST_DATA, ST_CSUM};
            cpu_rst      <= (state_d == ST_DONE);
            done         <= (state_d == ST_DONE);
            err          <= (state_d == ST_ERR);
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
`timescale 1ns/1ps
module tb_imem_loader;
    import mips_pkg::*;

    typedef logic [7:0]  byte_q_t[$];
    typedef logic [31:0] word_q_t[$];

    localparam int DEPTH = 128;
    localparam int AW    = 7;

    logic          f_clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_rst;
    logic          done;
    logic          err;
    logic [AW:0]   words_loaded;

    int tests = 0;
    int fails = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];

    always #5 f_clk = ~f_clk;

    imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .f_clk(f_clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_rst(cpu_rst), .done(done), .err(err), .words_loaded(words_loaded)
    );

    always @(negedge f_clk) begin
        if (mem_we) begin
            wa.push_back(32'(mem_addr));
            wd.push_back(mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge f_clk); #1;
        start = 1'b0;
    endtask

    // Streams bytes until all are accepted, the loader stops accepting, or the budget runs out.
    task automatic send(input byte_q_t b, input int gap, input int mark,
                        output int n_acc, output logic we_mark);
        int i = 0;
        int cyc = 0;
        logic v;
        logic acc;
        n_acc = 0;
        we_mark = 1'b0;
        while (i < b.size() && cyc < 4000 && in_ready) begin
            case (gap)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            in_valid = v;
            in_data  = v ? b[i] : 8'($urandom);
            start    = (gap == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
            acc      = v && in_ready;
            @(posedge f_clk); #1;
            cyc++;
            if (acc) begin
                if (i == mark) we_mark = mem_we;
                i++;
                n_acc++;
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic check_frame(input byte_q_t b, input word_q_t expw, input bit good,
                               input int gap, input string tag);
        int acc;
        logic wem;
        int n;
        n = expw.size();
        wa.delete();
        wd.delete();
        do_start();
        send(b, gap, HDR_BYTES + BYTES_PER_WORD * n - 1, acc, wem);
        check({tag, ":accepted"}, 32'(acc), 32'(b.size()));
        check({tag, ":done"}, 32'(done), 32'(good));
        check({tag, ":cpu_rst"}, 32'(cpu_rst), 32'(good));
        check({tag, ":err"}, 32'(err), 32'(!good));
        check({tag, ":in_ready"}, 32'(in_ready), 32'(0));
        check({tag, ":words_loaded"}, 32'(words_loaded), 32'(n));
        check({tag, ":nwrites"}, 32'(wa.size()), 32'(n));
        if (n > 0) check({tag, ":we_after_last_byte"}, 32'(wem), 32'(1));
        for (int k = 0; k < n && k < wa.size(); k++) begin
            check($sformatf("%s:addr%0d", tag, k), wa[k], 32'(k));
            check($sformatf("%s:data%0d", tag, k), wd[k], expw[k]);
        end
    endtask

    // Reference frame builder: header, big-endian words, XOR checksum (optionally corrupted).
    task automatic run_load(input int n, input int gap, input bit corrupt, input string tag);
        word_q_t w;
        byte_q_t b;
        logic [7:0] x;
        for (int k = 0; k < n; k++) w.push_back($urandom);
        b.push_back(8'(n >> 8));
        b.push_back(8'(n));
        for (int k = 0; k < n; k++)
            for (int s = 3; s >= 0; s--) b.push_back(8'(w[k] >> (8 * s)));
        x = 8'h00;
        for (int k = 0; k < b.size(); k++) x = x ^ b[k];
        b.push_back(corrupt ? ~x : x);
        check_frame(b, w, !corrupt, gap, tag);
    endtask

    initial begin
        byte_q_t nom;
        byte_q_t bad;
        word_q_t nomw;
        word_q_t none;
        byte_q_t b;
        int acc;
        logic wem;

        nom  = '{8'h00, 8'h02, 8'h20, 8'h0a, 8'h00, 8'h05, 8'h20, 8'h0b, 8'h00, 8'h07, 8'h01};
        bad  = '{8'h00, 8'h02, 8'h20, 8'h0a, 8'h00, 8'h05, 8'h20, 8'h0b, 8'h00, 8'h07, 8'h00};
        nomw = '{32'h200a0005, 32'h200b0007};

        repeat (2) @(posedge f_clk);
        #1;
        check("rst:in_ready", 32'(in_ready), 32'(0));
        check("rst:mem_we", 32'(mem_we), 32'(0));
        check("rst:cpu_rst", 32'(cpu_rst), 32'(0));
        check("rst:done", 32'(done), 32'(0));
        check("rst:err", 32'(err), 32'(0));
        check("rst:mem_addr", 32'(mem_addr), 32'(0));
        check("rst:mem_wdata", mem_wdata, 32'(0));
        check("rst:words_loaded", 32'(words_loaded), 32'(0));
        rst = 1'b1;
        @(posedge f_clk); #1;
        check("idle:in_ready", 32'(in_ready), 32'(0));

        check_frame(nom, nomw, 1'b1, 0, "nominal");

        do_start();
        check("restart:cpu_rst", 32'(cpu_rst), 32'(0));
        check("restart:done", 32'(done), 32'(0));
        check("restart:in_ready", 32'(in_ready), 32'(1));

        check_frame(bad, nomw, 1'b0, 0, "badcsum");

        wa.delete();
        do_start();
        b = '{8'h00, 8'h81};
        send(b, 0, -1, acc, wem);
        check("oversize:accepted", 32'(acc), 32'(2));
        check("oversize:err", 32'(err), 32'(1));
        check("oversize:in_ready", 32'(in_ready), 32'(0));
        check("oversize:cpu_rst", 32'(cpu_rst), 32'(0));
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (3) @(posedge f_clk);
        #1;
        in_valid = 1'b0;
        check("oversize:in_ready_later", 32'(in_ready), 32'(0));
        check("oversize:nwrites", 32'(wa.size()), 32'(0));
        check("oversize:words_loaded", 32'(words_loaded), 32'(0));

        b = '{8'h00, 8'h00, 8'h00};
        check_frame(b, none, 1'b1, 0, "zero");

        check_frame(nom, nomw, 1'b1, 1, "backpressure");

        for (int it = 0; it < 6; it++)
            run_load($urandom_range(1, 6), $urandom_range(0, 2), ($urandom_range(0, 3) == 0),
                     $sformatf("rand%0d", it));
        run_load(DEPTH, 0, 1'b0, "full_depth");

        wa.delete();
        do_start();
        b = nom[0:4];
        send(b, 0, -1, acc, wem);
        check("midrst:accepted", 32'(acc), 32'(5));
        in_valid = 1'b1;
        in_data  = nom[5];
        rst      = 1'b0;
        @(posedge f_clk); #1;
        in_valid = 1'b0;
        check("midrst:in_ready", 32'(in_ready), 32'(0));
        check("midrst:mem_we", 32'(mem_we), 32'(0));
        check("midrst:cpu_rst", 32'(cpu_rst), 32'(0));
        check("midrst:done", 32'(done), 32'(0));
        check("midrst:err", 32'(err), 32'(0));
        check("midrst:mem_addr", 32'(mem_addr), 32'(0));
        check("midrst:mem_wdata", mem_wdata, 32'(0));
        check("midrst:words_loaded", 32'(words_loaded), 32'(0));
        rst = 1'b1;
        @(posedge f_clk); #1;
        check("midrst:nwrites", 32'(wa.size()), 32'(0));
        run_load(3, 2, 1'b0, "after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
